// File: rtl/afifo_wr_arbiter.sv
// Round-robin, burst-locking arbiter that shares one AFIFO write port among NUM_REQ
// producers. The write strobe is combinational so wr_full blocks a write in the same cycle.
module afifo_wr_arbiter #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned MAX_BURST  = 4,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                          clk_wr,
   input  logic                          rst_wr_n,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            gnt,
   input  logic                          wr_full,
   output logic                          wr_en,
   output logic [DATA_WIDTH-1:0]         wdata,
   output logic                          busy,
   output logic [CNT_WIDTH-1:0]          wr_cnt
);

   localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned BEAT_W = $clog2(MAX_BURST + 1);

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic [IDX_W-1:0]      owner;
   logic [IDX_W-1:0]      owner_nxt;
   logic [IDX_W-1:0]      owner_inc;
   logic [IDX_W-1:0]      rr_ptr;
   logic [IDX_W-1:0]      rr_ptr_nxt;
   logic [IDX_W-1:0]      rr_pick;
   logic                  rr_found;
   int unsigned           rr_idx;
   logic [BEAT_W-1:0]     beat_cnt;
   logic [BEAT_W-1:0]     beat_cnt_nxt;
   logic [CNT_WIDTH-1:0]  wr_cnt_nxt;
   logic                  accept;
   logic [DATA_WIDTH-1:0] lane_data [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
      assign lane_data[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
   end

   assign owner_inc = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);

   // First requesting lane at or after rr_ptr, wrapping modulo NUM_REQ
   always_comb begin
      rr_pick  = rr_ptr;
      rr_found = 1'b0;
      rr_idx   = 0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         rr_idx = (32'(rr_ptr) + i) % NUM_REQ;
         if (!rr_found && req[IDX_W'(rr_idx)]) begin
            rr_found = 1'b1;
            rr_pick  = IDX_W'(rr_idx);
         end
      end
   end

   always_ff @(posedge clk_wr or negedge rst_wr_n) begin
      if (!rst_wr_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      owner_nxt    = owner;
      rr_ptr_nxt   = rr_ptr;
      beat_cnt_nxt = beat_cnt;
      wr_cnt_nxt   = wr_cnt;
      case (state)
         IDLE: begin
            if (|req) begin
               state_nxt    = BURST;
               owner_nxt    = rr_pick;
               beat_cnt_nxt = '0;
            end
         end
         BURST: begin
            if (!req[owner]) begin
               state_nxt  = IDLE;
               rr_ptr_nxt = owner_inc;
            end else if (!wr_full) begin
               beat_cnt_nxt = beat_cnt + BEAT_W'(1);
               wr_cnt_nxt   = wr_cnt + CNT_WIDTH'(1);
               if (req_last[owner] || (beat_cnt == BEAT_W'(MAX_BURST - 1))) begin
                  state_nxt  = IDLE;
                  rr_ptr_nxt = owner_inc;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      accept = (state == BURST) && req[owner] && !wr_full;
      wr_en  = accept;
      busy   = (state == BURST);
      gnt    = '0;
      wdata  = '0;
      if (accept) begin
         gnt   = NUM_REQ'(1) << owner;
         wdata = lane_data[owner];
      end
   end

   always_ff @(posedge clk_wr or negedge rst_wr_n) begin
      if (!rst_wr_n) begin
         owner    <= '0;
         rr_ptr   <= '0;
         beat_cnt <= '0;
         wr_cnt   <= '0;
      end else begin
         owner    <= owner_nxt;
         rr_ptr   <= rr_ptr_nxt;
         beat_cnt <= beat_cnt_nxt;
         wr_cnt   <= wr_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_afifo_wr_arbiter.sv
// Bench for afifo_wr_arbiter: directed vector table, corner-case sequences and random
// traffic, all compared cycle by cycle against a behavioural arbiter model.
module tb_afifo_wr_arbiter;

   localparam int unsigned DW = 32;
   localparam int unsigned N  = 4;
   localparam int unsigned MB = 4;
   localparam int unsigned CW = 16;

   logic            clk_wr = 1'b0;
   logic            rst_wr_n;
   logic [N-1:0]    req;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_last;
   logic [N-1:0]    gnt;
   logic            wr_full;
   logic            wr_en;
   logic [DW-1:0]   wdata;
   logic            busy;
   logic [CW-1:0]   wr_cnt;

   always #5 clk_wr = ~clk_wr;

   afifo_wr_arbiter #(
      .DATA_WIDTH(DW), .NUM_REQ(N), .MAX_BURST(MB), .CNT_WIDTH(CW)
   ) dut (
      .clk_wr(clk_wr), .rst_wr_n(rst_wr_n), .req(req), .req_data(req_data),
      .req_last(req_last), .gnt(gnt), .wr_full(wr_full), .wr_en(wr_en),
      .wdata(wdata), .busy(busy), .wr_cnt(wr_cnt)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Model: who holds the port, how many beats it has written, where the next search starts
   bit          m_busy;
   int          m_owner;
   int          m_ptr;
   int          m_beats;
   logic [CW-1:0] m_cnt;

   logic          s_wr_en;
   logic [N-1:0]  s_gnt;
   logic [DW-1:0] s_wdata;
   logic          s_busy;
   logic [CW-1:0] s_cnt;
   int            wlog[$];

   typedef struct {
      bit            rst;
      logic [N-1:0]  rq;
      logic [N-1:0]  last;
      logic          full;
      logic          en;
      logic [N-1:0]  g;
      logic          bsy;
      logic [DW-1:0] wd;
      logic [CW-1:0] cnt;
   } vec_t;

   vec_t tbl[9];
   localparam logic [N*DW-1:0] TDATA = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hA5A5_A5A5};
   localparam logic [N*DW-1:0] IDATA = {32'd3, 32'd2, 32'd1, 32'd0};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_busy  = 1'b0;
      m_owner = 0;
      m_ptr   = 0;
      m_beats = 0;
      m_cnt   = '0;
   endtask

   // Called at a falling edge; returns at the next falling edge
   task automatic step(input logic [N-1:0] r, input logic [N*DW-1:0] d,
                       input logic [N-1:0] l, input logic f, input string tag);
      logic          e_acc;
      logic [N-1:0]  e_gnt;
      logic [DW-1:0] e_wd;
      int            c;
      req = r; req_data = d; req_last = l; wr_full = f;
      #1;
      e_acc = m_busy && r[m_owner] && !f;
      e_gnt = e_acc ? (N'(1) << m_owner) : '0;
      e_wd  = e_acc ? d[m_owner*DW +: DW] : '0;
      chk({tag, ".wr_en"}, 64'(wr_en), 64'(e_acc));
      chk({tag, ".gnt"},   64'(gnt),   64'(e_gnt));
      chk({tag, ".wdata"}, 64'(wdata), 64'(e_wd));
      chk({tag, ".busy"},  64'(busy),  64'(m_busy));
      chk({tag, ".wr_cnt"}, 64'(wr_cnt), 64'(m_cnt));
      s_wr_en = wr_en; s_gnt = gnt; s_wdata = wdata; s_busy = busy; s_cnt = wr_cnt;
      if (wr_en) begin
         for (int k = 0; k < int'(N); k++) if (gnt[k]) wlog.push_back(k);
      end
      @(posedge clk_wr);
      if (!m_busy) begin
         if (r != '0) begin
            for (int k = 0; k < int'(N); k++) begin
               c = (m_ptr + k) % int'(N);
               if (r[c]) begin
                  m_owner = c;
                  break;
               end
            end
            m_busy  = 1'b1;
            m_beats = 0;
         end
      end else if (!r[m_owner]) begin
         m_busy = 1'b0;
         m_ptr  = (m_owner + 1) % int'(N);
      end else if (!f) begin
         m_beats++;
         m_cnt++;
         if (l[m_owner] || m_beats == int'(MB)) begin
            m_busy = 1'b0;
            m_ptr  = (m_owner + 1) % int'(N);
         end
      end
      @(negedge clk_wr);
   endtask

   task automatic do_reset();
      rst_wr_n = 1'b0; req = '0; req_last = '0; wr_full = 1'b0; req_data = '0;
      #1;
      chk("rst.wr_en", 64'(wr_en), 64'(0));
      chk("rst.gnt", 64'(gnt), 64'(0));
      chk("rst.busy", 64'(busy), 64'(0));
      chk("rst.wr_cnt", 64'(wr_cnt), 64'(0));
      model_reset();
      @(posedge clk_wr);
      @(negedge clk_wr);
      rst_wr_n = 1'b1;
   endtask

   initial begin
      logic [N*DW-1:0] rd;
      rst_wr_n = 1'b0; req = '0; req_last = '0; wr_full = 1'b0; req_data = '0;
      model_reset();

      tbl[0] = '{1'b1, 4'b0001, 4'b0001, 1'b0, 1'b0, 4'b0000, 1'b0, 32'h0,         16'd0};
      tbl[1] = '{1'b0, 4'b0001, 4'b0001, 1'b0, 1'b1, 4'b0001, 1'b1, 32'hA5A5_A5A5, 16'd0};
      tbl[2] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 32'h0,         16'd1};
      tbl[3] = '{1'b1, 4'b1100, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 32'h0,         16'd0};
      tbl[4] = '{1'b0, 4'b1100, 4'b0000, 1'b0, 1'b1, 4'b0100, 1'b1, 32'h2222_2222, 16'd0};
      tbl[5] = '{1'b0, 4'b1100, 4'b0100, 1'b0, 1'b1, 4'b0100, 1'b1, 32'h2222_2222, 16'd1};
      tbl[6] = '{1'b0, 4'b1011, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 32'h0,         16'd2};
      tbl[7] = '{1'b0, 4'b1011, 4'b1000, 1'b0, 1'b1, 4'b1000, 1'b1, 32'h3333_3333, 16'd2};
      tbl[8] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 32'h0,         16'd3};

      @(negedge clk_wr);
      for (int i = 0; i < 9; i++) begin
         if (tbl[i].rst) do_reset();
         step(tbl[i].rq, TDATA, tbl[i].last, tbl[i].full, $sformatf("tbl%0d", i));
         chk($sformatf("tbl%0d.en", i),   64'(s_wr_en), 64'(tbl[i].en));
         chk($sformatf("tbl%0d.g", i),    64'(s_gnt),   64'(tbl[i].g));
         chk($sformatf("tbl%0d.busy", i), 64'(s_busy),  64'(tbl[i].bsy));
         chk($sformatf("tbl%0d.wd", i),   64'(s_wdata), 64'(tbl[i].wd));
         chk($sformatf("tbl%0d.cnt", i),  64'(s_cnt),   64'(tbl[i].cnt));
      end

      // All lanes requesting: four full bursts in lane order with idle gaps
      do_reset();
      wlog.delete();
      repeat (20) step(4'b1111, IDATA, 4'b0000, 1'b0, "rr");
      chk("rr.cnt", 64'(wr_cnt), 64'(16));
      chk("rr.nlog", 64'(wlog.size()), 64'(16));
      for (int i = 0; i < 16 && i < wlog.size(); i++)
         chk($sformatf("rr.lane%0d", i), 64'(wlog[i]), 64'(i / 4));

      // Lane 1 stalls on wr_full after one beat, then finishes its burst
      do_reset();
      wlog.delete();
      step(4'b0010, IDATA, 4'b0000, 1'b0, "st");
      step(4'b0010, IDATA, 4'b0000, 1'b0, "st");
      repeat (5) begin
         step(4'b1111, IDATA, 4'b0000, 1'b1, "st_full");
         chk("st.blocked", 64'(s_wr_en), 64'(0));
      end
      chk("st.nlog1", 64'(wlog.size()), 64'(1));
      repeat (3) step(4'b1111, IDATA, 4'b0000, 1'b0, "st");
      chk("st.nlog4", 64'(wlog.size()), 64'(4));
      for (int i = 0; i < wlog.size(); i++) chk("st.lane", 64'(wlog[i]), 64'(1));
      step(4'b1111, IDATA, 4'b0000, 1'b0, "st");
      chk("st.idle", 64'(s_busy), 64'(0));
      step(4'b1111, IDATA, 4'b0000, 1'b0, "st");
      chk("st.next", 64'(s_gnt), 64'(4'b0100));

      // Lane 0 abandons after one beat; rotation moves to lane 1
      do_reset();
      step(4'b0001, IDATA, 4'b0000, 1'b0, "ab");
      step(4'b0001, IDATA, 4'b0000, 1'b0, "ab");
      step(4'b0010, IDATA, 4'b0000, 1'b0, "ab");
      chk("ab.nowrite", 64'(s_wr_en), 64'(0));
      step(4'b0011, IDATA, 4'b0000, 1'b0, "ab");
      chk("ab.idle", 64'(s_busy), 64'(0));
      step(4'b0011, IDATA, 4'b0000, 1'b0, "ab");
      chk("ab.next", 64'(s_gnt), 64'(4'b0010));

      // Reset in the middle of lane 3's second beat
      do_reset();
      step(4'b1000, IDATA, 4'b0000, 1'b0, "mr");
      step(4'b1000, IDATA, 4'b0000, 1'b0, "mr");
      req = 4'b1000; req_last = '0; wr_full = 1'b0; req_data = IDATA;
      #1;
      chk("mr.beat2", 64'(wr_en), 64'(1));
      #2;
      rst_wr_n = 1'b0;
      #1;
      chk("mr.wr_en", 64'(wr_en), 64'(0));
      chk("mr.gnt", 64'(gnt), 64'(0));
      chk("mr.busy", 64'(busy), 64'(0));
      chk("mr.wr_cnt", 64'(wr_cnt), 64'(0));
      model_reset();
      @(posedge clk_wr);
      @(negedge clk_wr);
      rst_wr_n = 1'b1;
      step(4'b1000, IDATA, 4'b0000, 1'b0, "mr");
      chk("mr.idle", 64'(s_busy), 64'(0));
      step(4'b1000, IDATA, 4'b0000, 1'b0, "mr");
      chk("mr.regrant", 64'(s_gnt), 64'(4'b1000));

      // Random traffic against the model
      do_reset();
      repeat (400) begin
         for (int k = 0; k < int'(N); k++) rd[k*DW +: DW] = $urandom;
         step(N'($urandom), rd, N'($urandom), ($urandom_range(0, 3) == 0), "rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/afifo_wr_arbiter.md
Name: afifo_wr_arbiter

Overview:
Write-side arbiter sharing the single AFIFO write port (wr_en/wdata) among NUM_REQ requesters in the write clock domain. Round-robin grant with burst locking: one requester owns the port until it ends its burst, hits MAX_BURST beats, or drops its request. Never writes while the AFIFO reports wr_full. Sits between producer blocks and AFIFO write inputs.

Parameters:
DATA_WIDTH, 32, width of each data word and of wdata
NUM_REQ, 4, number of requesters (2..8)
MAX_BURST, 4, max beats per grant before forced rotation (1..16)
CNT_WIDTH, 16, width of the accepted-write counter

Ports:
clk_wr  input  1  write-domain clock, all logic on rising edge
rst_wr_n  input  1  asynchronous active-low reset
req  input  NUM_REQ  per-requester write request, level, held until accepted
req_data  input  NUM_REQ*DATA_WIDTH  requester i word at bits [i*DATA_WIDTH +: DATA_WIDTH]
req_last  input  NUM_REQ  marks the current word as final beat of requester's burst
gnt  output  NUM_REQ  one-hot accept pulse: word of requester i consumed this cycle
wr_full  input  1  AFIFO full flag (write domain)
wr_en  output  1  AFIFO write enable
wdata  output  DATA_WIDTH  AFIFO write data
busy  output  1  high while a burst is owned (state BURST)
wr_cnt  output  CNT_WIDTH  total words written since reset, wraps

Behaviour:
- Registered state: fsm (IDLE, BURST), owner index, rr_ptr index, beat_cnt, wr_cnt.
- Reset (async, rst_wr_n=0): fsm=IDLE, owner=0, rr_ptr=0, beat_cnt=0, wr_cnt=0; hence gnt=0, wr_en=0, wdata=0, busy=0. Reset mid-burst discards ownership immediately; no write in a cycle with reset asserted.
- accept = (fsm==BURST) & req[owner] & ~wr_full (combinational).
- wr_en = accept; gnt = accept ? onehot(owner) : 0; wdata = accept ? req_data[owner] : 0. Combinational from registered state and current inputs, so wr_full blocks the write in the same cycle (no overflow).
- busy = (fsm==BURST).
- IDLE: if |req, owner <= first index with req set searching rr_ptr, rr_ptr+1, ... mod NUM_REQ; beat_cnt<=0; fsm<=BURST. No write in the IDLE cycle: 1-cycle arbitration latency, minimum one idle cycle between bursts.
- BURST, accept: beat_cnt++, wr_cnt++. If req_last[owner] or beat_cnt==MAX_BURST-1: fsm<=IDLE, rr_ptr<=(owner+1) mod NUM_REQ.
- BURST, req[owner]=0: burst abandoned; fsm<=IDLE, rr_ptr<=(owner+1) mod NUM_REQ, no write.
- BURST, req[owner]=1 and wr_full=1: stall; hold state, beat_cnt, owner; other requesters wait.
- Requests from non-owners are ignored during BURST; no preemption.
- rr_ptr rotation guarantees each continuously requesting requester is granted within NUM_REQ arbitration rounds.
- wr_cnt wraps 2^CNT_WIDTH-1 -> 0 silently.
- req_last on non-owner lanes is don't-care.

Test Plan:
- Reset then req=4'b0001, req_data[0]=32'hA5A5A5A5, req_last[0]=1 -> IDLE cycle, next cycle wr_en=1, wdata=32'hA5A5A5A5, gnt=4'b0001, then IDLE; wr_cnt=1.
- req=4'b1111 held, all req_last=0, words = lane index -> four bursts of exactly 4 beats each, owner order 0,1,2,3, one idle cycle between; wr_cnt=16.
- req[2] burst, req_last on beat 2 -> exactly 2 writes from lane 2, then owner 3 (if requesting) next, rr_ptr=3.
- Lane 1 in BURST, wr_full=1 for 5 cycles after beat 1 -> wr_en=0 and gnt=0 during stall, beat_cnt holds, remaining 3 beats written after wr_full=0; no other lane granted.
- Lane 0 in BURST drops req after 1 beat -> next cycle IDLE, rr_ptr=1, no further lane 0 writes.
- Assert rst_wr_n=0 mid-burst (beat 2 of lane 3) -> wr_en, gnt, busy, wr_cnt go 0 immediately; after release with req=4'b1000 arbitration restarts from rr_ptr=0 and grants lane 3.
